// File: rtl/ysyx_22050854_divider.sv
// Iterative radix-2 shift-subtract divider for RV64M DIV/DIVU/REM/REMU and their W forms.
// Quotient and remainder are produced together and presented with a one-cycle out_valid pulse.
module ysyx_22050854_divider #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  input  logic            div_valid,
  input  logic            div_signed,
  input  logic            divw,
  input  logic            flush,
  output logic            div_ready,
  output logic            out_valid,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  localparam int HALF = XLEN / 2;
  localparam int CW   = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state, state_nxt;
  logic [XLEN-1:0] pr, dq, dvs;
  logic [CW-1:0]   cnt;
  logic            q_neg, r_neg, w_op;

  logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag, min_val;
  logic            accept, div_zero, ovf;
  logic [XLEN:0]   shifted, diff;
  logic            q_bit;
  logic [XLEN-1:0] pr_nxt, dq_nxt, q_fix, r_fix;

  function automatic logic [XLEN-1:0] sext_w(input logic [XLEN-1:0] v, input logic w);
    return w ? {{HALF{v[HALF-1]}}, v[HALF-1:0]} : v;
  endfunction

  assign div_ready = (state == IDLE);
  assign out_valid = (state == DONE) & ~flush;
  assign accept    = div_valid & div_ready & ~flush;

  // NOTE: every variable written in an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    a_ext = dividend;
    b_ext = divisor;
    if (divw) begin
      a_ext = {{HALF{div_signed & dividend[HALF-1]}}, dividend[HALF-1:0]};
      b_ext = {{HALF{div_signed & divisor[HALF-1]}},  divisor[HALF-1:0]};
    end
  end

  assign a_mag    = (div_signed & a_ext[XLEN-1]) ? -a_ext : a_ext;
  assign b_mag    = (div_signed & b_ext[XLEN-1]) ? -b_ext : b_ext;
  // Most-negative value as it appears after the word path has sign-extended it.
  assign min_val  = divw ? {{(HALF+1){1'b1}}, {(HALF-1){1'b0}}} : {1'b1, {(XLEN-1){1'b0}}};
  assign div_zero = (b_ext == '0);
  assign ovf      = div_signed & (a_ext == min_val) & (b_ext == '1);

  // One restoring step: the 65-bit trial subtract's sign bit decides the quotient bit.
  assign shifted = {pr, dq[XLEN-1]};
  assign diff    = shifted - {1'b0, dvs};
  assign q_bit   = ~diff[XLEN];
  assign pr_nxt  = q_bit ? diff[XLEN-1:0] : shifted[XLEN-1:0];
  assign dq_nxt  = {dq[XLEN-2:0], q_bit};
  assign q_fix   = sext_w(q_neg ? -dq_nxt : dq_nxt, w_op);
  assign r_fix   = sext_w(r_neg ? -pr_nxt : pr_nxt, w_op);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = (div_zero | ovf) ? DONE : CALC;
      CALC: begin
        if (flush)                 state_nxt = IDLE;
        else if (cnt == CW'(1))    state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      q_neg     <= 1'b0;
      r_neg     <= 1'b0;
      w_op      <= 1'b0;
      pr        <= '0;
      dq        <= '0;
      dvs       <= '0;
      quotient  <= '0;
      remainder <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (accept) begin
          w_op  <= divw;
          q_neg <= div_signed & (a_ext[XLEN-1] ^ b_ext[XLEN-1]);
          r_neg <= div_signed & a_ext[XLEN-1];
          dvs   <= b_mag;
          pr    <= '0;
          // Word magnitudes fit in the low half; park them at the top so the MSB stream starts at bit 31.
          dq    <= divw ? {a_mag[HALF-1:0], {HALF{1'b0}}} : a_mag;
          cnt   <= divw ? CW'(HALF) : CW'(XLEN);
          if (div_zero) begin
            quotient  <= '1;
            remainder <= sext_w(a_ext, divw);
          end else if (ovf) begin
            quotient  <= a_ext;
            remainder <= '0;
          end
        end
        CALC: if (!flush) begin
          pr  <= pr_nxt;
          dq  <= dq_nxt;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            quotient  <= q_fix;
            remainder <= r_fix;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_22050854_divider.sv
// Randomized scoreboard bench for ysyx_22050854_divider: a driver issues operations and pushes
// expected results from an arithmetic reference model; a monitor pops and compares on out_valid.
module tb_ysyx_22050854_divider;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] dividend, divisor;
  logic        div_valid, div_signed, divw, flush;
  logic        div_ready, out_valid;
  logic [63:0] quotient, remainder;

  ysyx_22050854_divider #(.XLEN(64)) dut (
    .clk(clk), .rst(rst), .dividend(dividend), .divisor(divisor),
    .div_valid(div_valid), .div_signed(div_signed), .divw(divw), .flush(flush),
    .div_ready(div_ready), .out_valid(out_valid), .quotient(quotient), .remainder(remainder)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] q;
    logic [63:0] r;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  logic        prev_ov = 1'b0;
  logic [63:0] last_q = '0, last_r = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // RV64M semantics computed directly with SystemVerilog division.
  function automatic void ref_div(input logic [63:0] a, input logic [63:0] b, input logic s,
                                  input logic w, output logic [63:0] q, output logic [63:0] r,
                                  output logic special);
    if (w) begin
      logic [31:0] a32, b32, q32, r32;
      a32 = a[31:0];
      b32 = b[31:0];
      special = (b32 == 0) || (s && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF);
      if (b32 == 0) begin
        q32 = '1; r32 = a32;
      end else if (s && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin
        q32 = a32; r32 = '0;
      end else if (s) begin
        q32 = $signed(a32) / $signed(b32);
        r32 = $signed(a32) % $signed(b32);
      end else begin
        q32 = a32 / b32;
        r32 = a32 % b32;
      end
      q = {{32{q32[31]}}, q32};
      r = {{32{r32[31]}}, r32};
    end else begin
      special = (b == 0) || (s && a == 64'h8000_0000_0000_0000 && b == '1);
      if (b == 0) begin
        q = '1; r = a;
      end else if (s && a == 64'h8000_0000_0000_0000 && b == '1) begin
        q = a; r = '0;
      end else if (s) begin
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
      end else begin
        q = a / b;
        r = a % b;
      end
    end
  endfunction

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!div_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!div_ready) check("ready_timeout", {63'd0, div_ready}, 64'd1);
  endtask

  // Issues one op; when expect_out is clear the op is expected to be aborted and nothing is queued.
  task automatic issue(input logic [63:0] a, input logic [63:0] b, input logic s, input logic w,
                       input bit expect_out, input bit hold);
    logic [63:0] q, r;
    logic        special;
    exp_t        e;
    wait_ready();
    dividend = a; divisor = b; div_signed = s; divw = w; div_valid = 1'b1;
    @(posedge clk);
    #1;
    ref_div(a, b, s, w, q, r, special);
    if (expect_out) begin
      e.q = q; e.r = r;
      e.cyc = cyc + (special ? 0 : (w ? 32 : 64));
      sb.push_back(e);
      last_q = q; last_r = r;
    end
    if (hold) begin
      dividend = {$urandom, $urandom}; divisor = 64'd3;
      repeat (30) @(negedge clk);
    end
    div_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid) begin
      check("out_valid_single_pulse", {63'd0, prev_ov}, 64'd0);
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_out_valid actual=1 required=0 q=%h r=%h (t=%0t)", quotient, remainder, $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("quotient", quotient, e.q);
        check("remainder", remainder, e.r);
        check("latency_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
    prev_ov = out_valid;
  end

  initial begin
    rst = 1'b1; dividend = '0; divisor = '0; div_valid = 1'b0;
    div_signed = 1'b0; divw = 1'b0; flush = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_ready", {63'd0, div_ready}, 64'd1);
    check("reset_out_valid", {63'd0, out_valid}, 64'd0);
    check("reset_quotient", quotient, 64'd0);
    check("reset_remainder", remainder, 64'd0);

    // Directed cases from the operation rules
    issue(64'd100, 64'd7, 1'b0, 1'b0, 1, 0);
    issue(-64'sd7, 64'd2, 1'b1, 1'b0, 1, 0);
    issue(64'd7, -64'sd2, 1'b1, 1'b0, 1, 0);
    issue(64'd5, 64'd0, 1'b0, 1'b0, 1, 0);
    issue(64'h8000_0000_0000_0000, '1, 1'b1, 1'b0, 1, 0);
    issue(64'h0000_0001_FFFF_FFFE, 64'd2, 1'b0, 1'b1, 1, 0);
    issue(64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 1'b1, 1'b1, 1, 0);
    issue(64'h1234_0000_0000_0009, 64'hFFFF_FFFF_0000_0000, 1'b0, 1'b1, 1, 0);
    issue(64'h0000_0000_8000_0005, 64'd0, 1'b0, 1'b1, 1, 0);
    issue(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 1, 0);

    // div_valid held through CALC must not start a second operation
    issue(64'hDEAD_BEEF_0123_4567, 64'd12345, 1'b0, 1'b0, 1, 1);

    // Flush mid-CALC: no result, ready next cycle, outputs untouched
    issue(64'd100, 64'd7, 1'b0, 1'b0, 0, 0);
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_ready_next", {63'd0, div_ready}, 64'd1);
    check("flush_quotient_kept", quotient, last_q);
    check("flush_remainder_kept", remainder, last_r);
    issue(64'd9, 64'd4, 1'b0, 1'b0, 1, 0);

    // Flush together with div_valid in IDLE blocks acceptance
    wait_ready();
    dividend = 64'd50; divisor = 64'd5; div_signed = 1'b0; divw = 1'b0;
    div_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    div_valid = 1'b0; flush = 1'b0;
    check("flush_blocks_accept", {63'd0, div_ready}, 64'd1);

    // Randomized operations across operand classes
    for (int i = 0; i < 60; i++) begin
      logic [63:0] a, b;
      logic        s, w;
      s = 1'($urandom);
      w = 1'($urandom);
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      case ($urandom_range(0, 5))
        0: b = 64'($urandom_range(1, 255)) * (s && $urandom_range(0, 1) == 1 ? -64'sd1 : 64'sd1);
        1: b = w ? {b[63:32], 32'd0} : 64'd0;
        2: begin
          a = w ? {a[63:32], 32'h8000_0000} : 64'h8000_0000_0000_0000;
          b = w ? {b[63:32], 32'hFFFF_FFFF} : '1;
        end
        3: begin a = 64'($urandom_range(0, 1000)); b = 64'($urandom_range(1, 40)); end
        4: b = {32'd0, $urandom};
        default: ;
      endcase
      issue(a, b, s, w, 1, 0);
    end

    // Reset mid-CALC discards the operation and clears the outputs
    issue(64'd1000, 64'd3, 1'b0, 1'b0, 0, 0);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midcalc_reset_ready", {63'd0, div_ready}, 64'd1);
    check("midcalc_reset_out_valid", {63'd0, out_valid}, 64'd0);
    check("midcalc_reset_quotient", quotient, 64'd0);
    check("midcalc_reset_remainder", remainder, 64'd0);
    repeat (80) @(negedge clk);
    issue(64'd17, 64'd5, 1'b0, 1'b0, 1, 0);

    begin
      int n = 0;
      while (sb.size() != 0 && n < 300) begin
        @(negedge clk);
        n++;
      end
      @(negedge clk);
      check("scoreboard_drained", 64'(sb.size()), 64'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ysyx_22050854_divider.md
# ysyx_22050854_divider

Iterative radix-2 integer divider for the NPC execute stage, covering RV64M DIV, DIVU, REM, REMU, DIVW, DIVUW, REMW and REMUW. It is the inverse-direction companion of the Booth multiplier path. It accepts one operation through a valid/ready handshake, computes quotient and remainder together by shift-subtract on magnitudes, and returns both with a one-cycle `out_valid` pulse. The EXU stalls on `div_ready`/`out_valid`; the pipeline can abort it with `flush`.

## Interface
Parameters
- `XLEN`, 64: operand and result width. Only 64 is supported; the `divw` path assumes 32 = XLEN/2.

Ports
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `dividend` in XLEN: dividend operand, sampled on acceptance.
- `divisor` in XLEN: divisor operand, sampled on acceptance.
- `div_valid` in 1: request valid.
- `div_signed` in 1: 1 selects signed (DIV/REM), 0 selects unsigned; sampled on acceptance.
- `divw` in 1: 1 selects 32-bit word operation; sampled on acceptance.
- `flush` in 1: abort any in-flight operation.
- `div_ready` out 1: divider idle and able to accept.
- `out_valid` out 1: one-cycle pulse; `quotient` and `remainder` are valid in this cycle.
- `quotient` out XLEN: quotient result.
- `remainder` out XLEN: remainder result.

## Operation
- States: IDLE, CALC, DONE. `div_ready` = (state == IDLE), decoded directly from the state register.
- **Acceptance:** a request is accepted on an edge where `div_valid & div_ready & ~flush`.
- **Operand preparation at acceptance:**
  - If `divw`, take the low 32 bits of each operand and extend them to 64 bits: sign-extend if `div_signed`, zero-extend otherwise.
  - If `div_signed`, register the magnitude of each operand plus two flags: `q_neg` = sign(dividend) XOR sign(divisor), and `r_neg` = sign(dividend).
  - Otherwise both flags are 0.
- **Special cases, decided at acceptance (next state is DONE, not CALC):**
  - Divisor == 0 (after the 32-bit selection when `divw`): quotient = all ones, remainder = the prepared dividend.
  - Signed overflow: dividend = most-negative value and divisor = -1 (evaluated at 32 bits when `divw`). Result: quotient = dividend, remainder = 0.
- **CALC:**
  - Iteration count is 64, or 32 when `divw`.
  - Per edge: shift the partial remainder left by 1, bringing in the next dividend MSB. Trial-subtract the divisor magnitude using a 65-bit subtract. If the result is non-negative, keep the difference and shift in quotient bit 1; otherwise keep the shifted value and shift in 0.
  - A down-counter tracks iterations; on its last iteration the next state is DONE.
- **Result fix-up, on entry to DONE:**
  - Negate the quotient if `q_neg`; negate the remainder if `r_neg`.
  - If `divw`, sign-extend bit 31 of both results to 64 bits. This applies to DIVUW and REMUW as well, per RV64.
- **DONE:** `out_valid` = 1 for exactly one cycle, then the state returns to IDLE.
- `quotient`/`remainder` are registered. They hold their last values until the next completion and do not change during CALC.
- **Flush:**
  - In CALC or DONE, the next state is IDLE and `out_valid` is 0 in that cycle. No result is produced and the output registers keep their previous values.
  - In IDLE, flush blocks acceptance even if `div_valid` = 1.
- **Reset:** state = IDLE, `out_valid` = 0, `quotient` = 0, `remainder` = 0, counter = 0, flags = 0. Therefore `div_ready` = 1 in the first cycle after reset. A reset asserted mid-CALC discards the operation.
- `div_valid` during CALC/DONE is ignored, because `div_ready` = 0.

## Timing
- Acceptance edge = E0.
  - 64-bit op: CALC occupies edges E1..E64; `out_valid` is high in the cycle after E64. That is 65 cycles after the accept cycle.
  - `divw` op: `out_valid` is high in the cycle after E32.
  - Special case: `out_valid` is high in the cycle immediately after E0.
- `div_ready` rises in the cycle after the `out_valid` cycle, so back-to-back throughput is one operation per latency + 1 cycles.
- Flush asserted in cycle k (CALC/DONE): `div_ready` = 1 in cycle k+1.

## Test plan
- **Unsigned 64-bit:** dividend=100, divisor=7, `div_signed`=0, `divw`=0 → `out_valid` exactly 65 cycles after accept; quotient=14, remainder=2; `out_valid` is a single cycle.
- **Signed with mixed signs:** -7 / 2, `div_signed`=1 → quotient=0xFFFF_FFFF_FFFF_FFFD (-3), remainder=0xFFFF_FFFF_FFFF_FFFF (-1). Also 7 / -2 → quotient=-3, remainder=1.
- **Divide by zero and overflow:**
  - 5 / 0 unsigned → quotient=0xFFFF_FFFF_FFFF_FFFF, remainder=5, `out_valid` in the cycle after accept.
  - 0x8000_0000_0000_0000 / -1 signed → quotient=0x8000_0000_0000_0000, remainder=0, 1-cycle latency.
- **Word ops:**
  - `divw`=1, `div_signed`=0, dividend=0x0000_0001_FFFF_FFFE, divisor=2 → quotient=0x0000_0000_7FFF_FFFF, remainder=0, latency 33.
  - `divw`=1, `div_signed`=1, dividend=0x0000_0000_8000_0000, divisor=0xFFFF_FFFF → quotient=0xFFFF_FFFF_8000_0000, remainder=0.
- **Flush:**
  - Accept 100/7, assert `flush` 10 cycles later → no `out_valid` ever; `div_ready`=1 the next cycle; outputs unchanged.
  - Then accept 9/4 → quotient=2, remainder=1.
  - `flush`=1 together with `div_valid`=1 in IDLE → not accepted.
- **Reset:**
  - Assert `rst` for one cycle mid-CALC → in the next cycle `div_ready`=1, `out_valid`=0, `quotient`=`remainder`=0.
  - `div_valid` held high during CALC does not start a second operation.
